// File: rtl/bus_merge_pipe.sv
// Registered bus merger: {in_2 high field, op(A,B) middle field, in_1 low field}
// behind valid/ready handshakes and a 2-entry FIFO, with a wrapping output-beat counter.
module bus_merge_pipe #(
    parameter int unsigned LO_W  = 2,
    parameter int unsigned MID_W = 2,
    parameter int unsigned HI_W  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MID_W+LO_W-1:0]         in_1,
    input  logic [HI_W+MID_W-1:0]         in_2,
    input  logic                          mode_we,
    input  logic [1:0]                    mode_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [HI_W+MID_W+LO_W-1:0]    out_1,
    output logic [CNT_W-1:0]              beat_count
);

    localparam int unsigned IN1_W = MID_W + LO_W;
    localparam int unsigned IN2_W = HI_W + MID_W;
    localparam int unsigned OUT_W = HI_W + MID_W + LO_W;

    typedef enum logic [1:0] {
        ModeAnd  = 2'b00,
        ModeOr   = 2'b01,
        ModeXor  = 2'b10,
        ModeNand = 2'b11
    } mode_e;

    mode_e              mode_q;
    logic [1:0]         occ_q;
    logic [OUT_W-1:0]   slot0_q;
    logic [OUT_W-1:0]   slot1_q;
    logic [CNT_W-1:0]   beat_count_q;

    logic [MID_W-1:0]   op_a;
    logic [MID_W-1:0]   op_b;
    logic [MID_W-1:0]   mid;
    logic [OUT_W-1:0]   merged;
    logic               push;
    logic               pop;

    assign op_a = in_1[IN1_W-1:LO_W];
    assign op_b = in_2[MID_W-1:0];

    always_comb begin
        mid = '0;
        case (mode_q)
            ModeAnd:  mid = op_a & op_b;
            ModeOr:   mid = op_a | op_b;
            ModeXor:  mid = op_a ^ op_b;
            ModeNand: mid = ~(op_a & op_b);
            default:  mid = '0;
        endcase
    end

    assign merged = {in_2[IN2_W-1:MID_W], mid, in_1[LO_W-1:0]};

    // in_ready looks only at registered occupancy and rst, never at out_ready.
    assign in_ready   = (occ_q != 2'd2) && !rst;
    assign out_valid  = (occ_q != 2'd0);
    assign out_1      = slot0_q;
    assign beat_count = beat_count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= ModeAnd;
            occ_q        <= 2'd0;
            slot0_q      <= '0;
            slot1_q      <= '0;
            beat_count_q <= '0;
        end else begin
            if (mode_we) begin
                mode_q <= mode_e'(mode_in);
            end
            if (pop) begin
                beat_count_q <= beat_count_q + CNT_W'(1);
            end
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        slot0_q <= merged;
                    end else begin
                        slot1_q <= merged;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    occ_q   <= occ_q - 2'd1;
                end
                // Both together only happens with one entry: new beat replaces the head.
                2'b11: begin
                    slot0_q <= merged;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
